// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM plus a small MMIO window (cycle counter, GPIO, scratch).
// One read per cycle with a registered result; unmapped accesses return 0 and pulse Mem_fault.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] DMEM_addr,
  input  logic [3:0]  DMEM_wr_byte_en,
  input  logic [31:0] DMEM_wr_data,
  input  logic        DMEM_wr_en,
  input  logic        DMEM_rst,
  output logic [31:0] DMEM_rd_data,
  output logic        Mem_fault,
  output logic [7:0]  Gpio_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] OFF_CYC_LO  = 2'd0;
  localparam logic [1:0] OFF_CYC_HI  = 2'd1;
  localparam logic [1:0] OFF_GPIO    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_rd_q;

  logic          is_ram, is_mmio, is_unmapped, wr_ok, ram_we;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;

  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   hi_q, hi_d;
  logic [7:0]    gpio_q, gpio_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   reg_rd_q, reg_rd_d;
  logic          src_ram_q, src_ram_d;
  logic          fault_q, fault_d;

  // RAM takes precedence if a parameter choice ever overlaps the MMIO window.
  always_comb begin
    is_ram      = ({1'b0, DMEM_addr} < RAM_BYTES);
    is_mmio     = !is_ram && (DMEM_addr[31:4] == MMIO_BASE[31:4]);
    is_unmapped = !is_ram && !is_mmio;
    mmio_off    = DMEM_addr[3:2];
    ram_idx     = DMEM_addr[AW+1:2];
    wr_ok       = DMEM_wr_en && !Reset;
    ram_we      = wr_ok && is_ram;
  end

  // RAM array: no reset, read-first, output register kept separate so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    ram_rd_q <= mem[ram_idx];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (DMEM_wr_byte_en[i]) mem[ram_idx][8*i +: 8] <= DMEM_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    cyc_d     = cyc_q + 64'd1;
    hi_d      = hi_q;
    gpio_d    = gpio_q;
    scratch_d = scratch_q;
    reg_rd_d  = 32'd0;
    src_ram_d = is_ram;
    fault_d   = is_unmapped;

    if (is_mmio) begin
      case (mmio_off)
        OFF_CYC_LO: begin
          reg_rd_d = cyc_q[31:0];
          if (!DMEM_rst) hi_d = cyc_q[63:32];
        end
        OFF_CYC_HI: reg_rd_d = hi_q;
        OFF_GPIO: begin
          reg_rd_d = {24'd0, gpio_q};
          if (wr_ok && DMEM_wr_byte_en[0]) gpio_d = DMEM_wr_data[7:0];
        end
        OFF_SCRATCH: begin
          reg_rd_d = scratch_q;
          if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
              if (DMEM_wr_byte_en[i]) scratch_d[8*i +: 8] = DMEM_wr_data[8*i +: 8];
            end
          end
        end
        default: reg_rd_d = 32'd0;
      endcase
    end

    // Read-register clear wins over the read result but never over writes or the fault pulse.
    if (DMEM_rst) begin
      reg_rd_d  = 32'd0;
      src_ram_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q     <= 64'd0;
      hi_q      <= 32'd0;
      gpio_q    <= 8'd0;
      scratch_q <= 32'd0;
      reg_rd_q  <= 32'd0;
      src_ram_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      hi_q      <= hi_d;
      gpio_q    <= gpio_d;
      scratch_q <= scratch_d;
      reg_rd_q  <= reg_rd_d;
      src_ram_q <= src_ram_d;
      fault_q   <= fault_d;
    end
  end

  assign DMEM_rd_data = src_ram_q ? ram_rd_q : reg_rd_q;
  assign Mem_fault    = fault_q;
  assign Gpio_out     = gpio_q;

endmodule
